sum_sequencer: RTL and testbench

Batch-accumulation controller for the team's 4-bit operand adder, packaged with the standard tile pinout. A host starts a batch of 1–8 operand pairs and streams them in with a valid/ready handshake. The block sequences one shared 4-bit add per pair into an 8-bit running total and flags completion with a one-cycle done pulse. The total stays on uo_out until the next batch starts.

---
 rtl/sum_sequencer_if.sv | 32 +++
 rtl/sum_sequencer.sv | 111 +++++++++++
 tb/tb_sum_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_sequencer_if.sv
// sum_sequencer_if
//   Groups the tile pinout of sum_sequencer into one bundle.
//   Signals:
//     ui_in   [7:0]  operand pair, [3:0]=a, [7:4]=b
//     uio_in  [7:0]  control: [0] start, [3:1] len_m1, [4] op_valid
//     uo_out  [7:0]  running / final accumulator
//     uio_out [7:0]  status: [5] op_ready, [6] busy, [7] done, [4:0]=0
//     uio_oe  [7:0]  output enables for uio_out (constant)
//     state   [1:0]  debug view of the controller state register
//   Modports: master = host side (drives inputs), slave = sum_sequencer.
//
//   Handshake: a pair is transferred on a rising edge where ena=1,
//   op_ready=1 and op_valid=1; op_ready never depends combinationally
//   on op_valid, and the host may hold op_valid high across transfers.
interface sum_sequencer_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [1:0] state;

   modport master (
      output ui_in, uio_in,
      input  uo_out, uio_out, uio_oe, state
   );

   modport slave (
      input  ui_in, uio_in,
      output uo_out, uio_out, uio_oe, state
   );
endinterface

// File: rtl/sum_sequencer.sv
// sum_sequencer
//   Batch-accumulation controller: a batch of 1-8 operand pairs is
//   started, each pair is collected by handshake and added (4-bit + 4-bit,
//   5-bit pair sum) into an 8-bit total, and a one-cycle done pulse marks
//   the end of the batch. The total stays visible until the next start.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (applies even when ena=0)
//     ena    clock enable; low freezes every register
//     bus    sum_sequencer_if.slave (operands, control, status, debug state)
module sum_sequencer (
   input logic           clk,
   input logic           rst_n,
   input logic           ena,
   sum_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      ADD     = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] acc;
   logic [3:0] remaining;
   logic [3:0] opa;
   logic [3:0] opb;
   logic       op_ready;
   logic       busy;
   logic       done;

   logic       start;
   logic [2:0] len_m1;
   logic       op_valid;
   logic [4:0] pair_sum;
   logic       unused_ok;

   assign start    = bus.uio_in[0];
   assign len_m1   = bus.uio_in[3:1];
   assign op_valid = bus.uio_in[4];
   assign unused_ok = &{1'b0, bus.uio_in[7:5]};

   // Pair sum is kept 5 bits wide; the worst-case batch (8 x 30 = 240)
   // fits in 8 bits, so the accumulator needs no saturation.
   assign pair_sum = {1'b0, opa} + {1'b0, opb};

   // Status flags are registered alongside the state so they follow the
   // state register exactly and never see the inputs combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= 8'd0;
         remaining <= 4'd0;
         opa       <= 4'd0;
         opb       <= 4'd0;
         op_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc       <= 8'd0;
                  remaining <= {1'b0, len_m1} + 4'd1;
                  state     <= COLLECT;
                  op_ready  <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            COLLECT: begin
               if (op_valid) begin
                  opa      <= bus.ui_in[3:0];
                  opb      <= bus.ui_in[7:4];
                  state    <= ADD;
                  op_ready <= 1'b0;
               end
            end
            ADD: begin
               acc       <= acc + {3'b000, pair_sum};
               remaining <= remaining - 4'd1;
               if (remaining == 4'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= COLLECT;
                  op_ready <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               op_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.uo_out  = acc;
   assign bus.uio_out = {done, busy, op_ready, 5'b00000};
   assign bus.uio_oe  = 8'b1110_0000;
   assign bus.state   = state;

endmodule

// File: tb/tb_sum_sequencer.sv
// tb_sum_sequencer
//   Directed bench for sum_sequencer: a table of complete batches with
//   hand-computed totals, plus hand-written sequences for reset, gaps
//   with ignored starts, mid-batch reset and ena freeze.
module tb_sum_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   always #5 clk = ~clk;

   sum_sequencer_if bus ();

   sum_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [2:0]  len_m1;
      logic [63:0] pairs;   // pair p in bits [8p+7:8p], b high nibble
      logic [7:0]  total;   // hand-computed final sum
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic sb_check(input string name);
      logic [7:0] expv;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard queue empty, got 0x%02h", name, bus.uo_out);
      end else begin
         expv = exp_q.pop_front();
         check(name, bus.uo_out, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full batch with op_valid held high; checks every edge of the sequence.
   task automatic run_batch(input logic [2:0] len_m1, input logic [63:0] pairs, input string tag);
      int         n;
      logic [7:0] running;
      n       = int'(len_m1) + 1;
      running = 8'd0;
      bus.uio_in = {4'b0000, len_m1, 1'b1};
      step();                                     // edge 0: start accepted
      bus.uio_in[0] = 1'b0;
      check($sformatf("%s_start_status", tag), bus.uio_out, 8'h60);
      check($sformatf("%s_start_acc", tag), bus.uo_out, 8'h00);
      for (int p = 0; p < n; p++) begin
         bus.ui_in     = pairs[p*8 +: 8];
         bus.uio_in[4] = 1'b1;
         step();                                  // edge 2p+1: handshake
         check($sformatf("%s_add_status_%0d", tag, p), bus.uio_out, 8'h40);
         running = running + 8'(pairs[p*8 +: 4]) + 8'(pairs[p*8+4 +: 4]);
         step();                                  // edge 2p+2: acc updated
         check($sformatf("%s_partial_%0d", tag, p), bus.uo_out, running);
         if (p < n - 1) begin
            check($sformatf("%s_collect_status_%0d", tag, p), bus.uio_out, 8'h60);
         end else begin
            check($sformatf("%s_done_status", tag), bus.uio_out, 8'hC0);
            sb_check($sformatf("%s_total", tag));
         end
      end
      bus.uio_in[4] = 1'b0;
      step();                                     // edge 2n+1: back in IDLE
      check($sformatf("%s_idle_status", tag), bus.uio_out, 8'h00);
      check($sformatf("%s_hold_total", tag), bus.uo_out, running);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   initial begin
      int         done_cnt;
      int         first_done;
      logic [7:0] running;
      logic [7:0] gap_pairs[3];

      vecs[0] = '{len_m1: 3'd0, pairs: 64'h0000_0000_0000_0097, total: 8'h10}; // 7+9
      vecs[1] = '{len_m1: 3'd7, pairs: 64'hFFFF_FFFF_FFFF_FFFF, total: 8'hF0}; // 8x30
      vecs[2] = '{len_m1: 3'd2, pairs: 64'h0000_0000_0065_4321, total: 8'h15}; // 3+7+11
      vecs[3] = '{len_m1: 3'd3, pairs: 64'h0000_0000_1188_F00F, total: 8'h30}; // 15+15+16+2
      vecs[4] = '{len_m1: 3'd1, pairs: 64'h0000_0000_0000_0000, total: 8'h00};

      // Reset with random inputs, ena random
      rst_n      = 1'b0;
      ena        = 1'($urandom_range(0, 1));
      bus.ui_in  = 8'($urandom);
      bus.uio_in = 8'($urandom);
      step();
      bus.ui_in  = 8'($urandom);
      bus.uio_in = 8'($urandom);
      step();
      check("reset_uo_out", bus.uo_out, 8'h00);
      check("reset_uio_out", bus.uio_out, 8'h00);
      check("reset_uio_oe", bus.uio_oe, 8'hE0);
      check("reset_state", 8'(bus.state), 8'h00);
      rst_n      = 1'b1;
      ena        = 1'b1;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      step();
      check("idle_after_reset", bus.uio_out, 8'h00);

      // Table-driven batches
      foreach (vecs[i]) exp_q.push_back(vecs[i].total);
      foreach (vecs[i]) run_batch(vecs[i].len_m1, vecs[i].pairs, $sformatf("vec%0d", i));

      // Handshake gaps with start pulsed while busy
      gap_pairs[0] = 8'h21;
      gap_pairs[1] = 8'h43;
      gap_pairs[2] = 8'h65;
      exp_q.push_back(8'h15);
      running    = 8'd0;
      done_cnt   = 0;
      bus.uio_in = 8'b0000_0101;                  // start, len_m1=2
      step();
      for (int p = 0; p < 3; p++) begin
         for (int g = 0; g < 3; g++) begin
            bus.uio_in = 8'b0000_1111;            // start with len_m1=7, no op_valid
            bus.ui_in  = 8'($urandom);
            step();
            check($sformatf("gap_state_%0d_%0d", p, g), 8'(bus.state), 8'h01);
            check($sformatf("gap_acc_%0d_%0d", p, g), bus.uo_out, running);
         end
         bus.uio_in = 8'h10;
         bus.ui_in  = gap_pairs[p];
         step();                                  // handshake
         bus.uio_in = 8'h01;                      // start during ADD
         step();
         running = running + 8'(gap_pairs[p][3:0]) + 8'(gap_pairs[p][7:4]);
         if (bus.uio_out[7]) done_cnt++;
      end
      sb_check("gap_total");
      bus.uio_in = 8'h01;                         // start during DONE cycle
      step();
      check("gap_done_start_ignored", 8'(bus.state), 8'h00);
      bus.uio_in = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.uio_out[7]) done_cnt++;
      end
      check("gap_done_count", 8'(done_cnt), 8'd1);
      check("gap_hold_total", bus.uo_out, 8'h15);

      // Reset mid-batch after the second of four handshakes
      bus.uio_in = 8'b0000_0111;                  // start, len_m1=3
      step();
      bus.uio_in = 8'h10;
      bus.ui_in  = 8'h11;
      step();                                     // handshake 1
      step();
      check("midrst_partial", bus.uo_out, 8'h02);
      bus.ui_in = 8'h22;
      step();                                     // handshake 2
      rst_n = 1'b0;
      step();
      check("midrst_uo_out", bus.uo_out, 8'h00);
      check("midrst_uio_out", bus.uio_out, 8'h00);
      check("midrst_state", 8'(bus.state), 8'h00);
      rst_n      = 1'b1;
      bus.uio_in = 8'h00;
      step();
      exp_q.push_back(8'h05);
      run_batch(3'd0, 64'h32, "midrst_recover");

      // ena freeze during COLLECT
      exp_q.push_back(8'h12);
      bus.uio_in = 8'b0000_0011;                  // start, len_m1=1
      step();                                     // edge 0
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin           // edges 1..4 frozen
         bus.uio_in = (i % 2 == 0) ? 8'h10 : 8'h00;
         bus.ui_in  = 8'($urandom);
         step();
         check($sformatf("freeze_state_%0d", i), 8'(bus.state), 8'h01);
         check($sformatf("freeze_status_%0d", i), bus.uio_out, 8'h60);
      end
      ena        = 1'b1;
      bus.uio_in = 8'h10;
      bus.ui_in  = 8'h54;
      first_done = -1;
      for (int e = 5; e < 15; e++) begin
         step();
         if (e == 5) bus.ui_in = 8'h36;
         if (bus.uio_out[7] && first_done < 0) begin
            first_done = e;
            sb_check("freeze_total");
            bus.uio_in = 8'h00;
         end
      end
      check("freeze_done_edge", 8'(first_done), 8'd8);
      check("freeze_end_state", 8'(bus.state), 8'h00);
      check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
